spi_reg_bank_poci: RTL and testbench



---
 rtl/spi_reg_pkg.sv | 26 ++
 rtl/spi_reg_bank_poci_serializer.sv | 48 ++++
 rtl/spi_reg_bank_poci.sv | 100 ++++++++++
 tb/tb_spi_reg_bank_poci.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared types, constants and address-decode helpers for the SPI register bank.
package spi_reg_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // Address 0 is the command slot and never names a register.
    localparam int unsigned ADDR_CMD        = 0;
    localparam byte_t       OOR_VAL_DEFAULT = 8'h00;

    // Read/write configuration registers live at 1..num_rw.
    function automatic logic is_rw_addr(input int unsigned addr, input int unsigned num_rw);
        return (addr != ADDR_CMD) && (addr <= num_rw);
    endfunction

    // Read-only status registers follow directly after the config block.
    function automatic logic is_ro_addr(input int unsigned addr, input int unsigned num_rw,
                                        input int unsigned num_ro);
        return (addr > num_rw) && (addr <= num_rw + num_ro);
    endfunction

endpackage

// File: rtl/spi_reg_bank_poci_serializer.sv
// POCI byte serializer: loads a byte on the byte-boundary flag and shifts it
// out MSB-first, one bit per sclk. A load in SHIFT restarts the byte so that
// consecutive bytes stream without a gap.
module poci_serializer
    import spi_reg_pkg::*;
(
    input  logic  sclk,
    input  logic  rstn,
    input  logic  txn_rstn,
    input  logic  load,
    input  byte_t byte_in,
    output logic  serial_out,
    output logic  busy
);

    // Either the global reset or the end-of-transaction reset clears the shifter.
    logic ser_rstn;
    assign ser_rstn = rstn & txn_rstn;

    ser_state_t  state_reg;
    byte_t       shift_reg;
    logic [2:0]  count_reg;

    // FSM, shifter and bit counter; load always wins over shifting.
    always_ff @(posedge sclk or negedge ser_rstn) begin
        if (!ser_rstn) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            count_reg <= '0;
        end else if (load) begin
            shift_reg <= byte_in;
            count_reg <= '0;
            state_reg <= SHIFT;
        end else if (state_reg == SHIFT) begin
            shift_reg <= {shift_reg[6:0], 1'b0};
            if (count_reg == 3'd7) begin
                count_reg <= '0;
                state_reg <= IDLE;
            end else begin
                count_reg <= count_reg + 3'd1;
            end
        end
    end

    assign serial_out = shift_reg[7];
    assign busy       = (state_reg == SHIFT);

endmodule

// File: rtl/spi_reg_bank_poci.sv
// SPI register bank: write-side config registers, synchronised status
// registers, a combinational read mux and the POCI serializer.
module spi_reg_bank_poci
    import spi_reg_pkg::*;
#(
    parameter int unsigned NUM_RW  = 8,
    parameter int unsigned NUM_RO  = 4,
    parameter int unsigned ADDR_W  = 8,
    parameter byte_t       OOR_VAL = OOR_VAL_DEFAULT
) (
    input  logic                  sclk,
    input  logic                  rstn,
    input  logic                  txn_rstn,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    input  logic                  load,
    input  logic [8*NUM_RO-1:0]   status_in,
    output logic                  serial_out,
    output logic [8*NUM_RW-1:0]   cfg_out,
    output logic                  busy,
    output logic                  err
);

    logic                txn_clr_n;
    logic [8*NUM_RO-1:0] status_sync1_reg;
    logic [8*NUM_RO-1:0] status_sync2_reg;
    byte_t               rd_val;

    assign txn_clr_n = rstn & txn_rstn;

    // One config register per RW address; each is visible on cfg_out directly.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_RW; gi++) begin : g_cfg
            byte_t cfg_reg;

            // Capture write data when this register's address is strobed.
            always_ff @(posedge sclk or negedge rstn) begin
                if (!rstn) begin
                    cfg_reg <= '0;
                end else if (wr_en && (wr_addr == ADDR_W'(gi + 1))) begin
                    cfg_reg <= wr_data;
                end
            end

            assign cfg_out[8*gi +: 8] = cfg_reg;
        end
    endgenerate

    // Sticky flag for writes that hit address 0, a status register or nothing.
    always_ff @(posedge sclk or negedge txn_clr_n) begin
        if (!txn_clr_n) begin
            err <= 1'b0;
        end else if (wr_en && !is_rw_addr(32'(wr_addr), NUM_RW)) begin
            err <= 1'b1;
        end
    end

    // Two-flop synchroniser for the core's status bits; stage two is the RO value.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            status_sync1_reg <= '0;
            status_sync2_reg <= '0;
        end else begin
            status_sync1_reg <= status_in;
            status_sync2_reg <= status_sync1_reg;
        end
    end

    // Read mux: config, synchronised status, or the out-of-range filler.
    always_comb begin
        rd_val = OOR_VAL;
        if (is_rw_addr(32'(rd_addr), NUM_RW)) begin
            for (int k = 0; k < NUM_RW; k++) begin
                if (rd_addr == ADDR_W'(k + 1)) begin
                    rd_val = cfg_out[8*k +: 8];
                end
            end
        end else if (is_ro_addr(32'(rd_addr), NUM_RW, NUM_RO)) begin
            for (int k = 0; k < NUM_RO; k++) begin
                if (rd_addr == ADDR_W'(NUM_RW + k + 1)) begin
                    rd_val = status_sync2_reg[8*k +: 8];
                end
            end
        end
    end

    poci_serializer u_ser (
        .sclk       (sclk),
        .rstn       (rstn),
        .txn_rstn   (txn_rstn),
        .load       (load),
        .byte_in    (rd_val),
        .serial_out (serial_out),
        .busy       (busy)
    );

endmodule

// File: tb/tb_spi_reg_bank_poci.sv
// Directed bench for spi_reg_bank_poci: inputs change and outputs are sampled
// 1 time unit after each rising sclk edge.
module tb_spi_reg_bank_poci;

    logic        sclk;
    logic        rstn;
    logic        txn_rstn;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_addr;
    logic        load;
    logic [31:0] status_in;
    logic        serial_out;
    logic [63:0] cfg_out;
    logic        busy;
    logic        err;

    int          vec_cnt;
    int          miss_cnt;
    logic [63:0] exp_cfg;

    spi_reg_bank_poci #(
        .NUM_RW  (8),
        .NUM_RO  (4),
        .ADDR_W  (8),
        .OOR_VAL (8'h00)
    ) dut (
        .sclk       (sclk),
        .rstn       (rstn),
        .txn_rstn   (txn_rstn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_addr    (rd_addr),
        .load       (load),
        .status_in  (status_in),
        .serial_out (serial_out),
        .cfg_out    (cfg_out),
        .busy       (busy),
        .err        (err)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        txn_rstn  = 1'b1;
        wr_en     = 1'($urandom);
        wr_addr   = 8'($urandom);
        wr_data   = 8'($urandom);
        rd_addr   = 8'($urandom);
        load      = 1'($urandom);
        status_in = $urandom;
        #1;
        tick();
        tick();
        vec_cnt++;
        if (cfg_out !== 64'h0) begin
            miss_cnt++;
            $display("FAIL reset_cfg: got %h want %h", cfg_out, 64'h0);
        end
        vec_cnt++;
        if ({serial_out, busy, err} !== 3'b000) begin
            miss_cnt++;
            $display("FAIL reset_flags: got so/busy/err=%b want 000", {serial_out, busy, err});
        end
        wr_en     = 1'b0;
        load      = 1'b0;
        wr_addr   = 8'h00;
        wr_data   = 8'h00;
        rd_addr   = 8'h00;
        status_in = 32'h0;
        rstn      = 1'b1;
        exp_cfg   = 64'h0;
        tick();
        $display("reset: cfg=%h so=%b busy=%b err=%b", cfg_out, serial_out, busy, err);
    endtask

    task automatic test_write_read();
        logic [7:0] exp_byte;
        exp_byte = 8'hC5;
        wr_en = 1'b1; wr_addr = 8'd3; wr_data = exp_byte;
        tick();
        wr_en = 1'b0;
        exp_cfg[23:16] = exp_byte;
        vec_cnt++;
        if (cfg_out[23:16] !== 8'hC5) begin
            miss_cnt++;
            $display("FAIL write_cfg3: got %h want c5", cfg_out[23:16]);
        end
        load = 1'b1; rd_addr = 8'd3;
        tick();
        load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (serial_out !== exp_byte[7-i] || busy !== 1'b1) begin
                miss_cnt++;
                $display("FAIL read_bit%0d: got so=%b busy=%b want so=%b busy=1",
                         i, serial_out, busy, exp_byte[7-i]);
            end
            tick();
        end
        vec_cnt++;
        if (busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL read_done: got busy=%b want 0", busy);
        end
        $display("write_read: wrote c5 to addr 3, cfg=%h", cfg_out);
    endtask

    task automatic test_illegal();
        logic [7:0] bad_addr [3];
        bad_addr[0] = 8'h00;
        bad_addr[1] = 8'd9;
        bad_addr[2] = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = bad_addr[i]; wr_data = 8'hEE;
            tick();
            vec_cnt++;
            if (err !== 1'b1 || cfg_out !== exp_cfg) begin
                miss_cnt++;
                $display("FAIL illegal_%h: got err=%b cfg=%h want err=1 cfg=%h",
                         bad_addr[i], err, cfg_out, exp_cfg);
            end
            $display("illegal write addr %h: err=%b", bad_addr[i], err);
        end
        wr_en = 1'b0;
        tick();
        tick();
        vec_cnt++;
        if (err !== 1'b1) begin
            miss_cnt++;
            $display("FAIL err_sticky: got %b want 1", err);
        end
        txn_rstn = 1'b0;
        #2;
        vec_cnt++;
        if (err !== 1'b0 || cfg_out !== exp_cfg) begin
            miss_cnt++;
            $display("FAIL txn_clear: got err=%b cfg=%h want err=0 cfg=%h", err, cfg_out, exp_cfg);
        end
        txn_rstn = 1'b1;
        tick();
        $display("txn_rstn pulse: err=%b cfg=%h", err, cfg_out);
    endtask

    task automatic test_status();
        logic [7:0] exp_byte;
        exp_byte = 8'h3A;
        status_in = {24'h0, exp_byte};
        tick();
        tick();
        load = 1'b1; rd_addr = 8'd9;
        tick();
        load = 1'b0;
        status_in = 32'h0000_00C5;
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (serial_out !== exp_byte[7-i]) begin
                miss_cnt++;
                $display("FAIL status_bit%0d: got %b want %b", i, serial_out, exp_byte[7-i]);
            end
            tick();
        end
        vec_cnt++;
        if (busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL status_done: got busy=%b want 0", busy);
        end
        $display("status read addr 9: streamed 3a");
    endtask

    task automatic test_oor_read();
        logic [7:0] rd_vals [2];
        rd_vals[0] = 8'h00;
        rd_vals[1] = 8'd13;
        for (int j = 0; j < 2; j++) begin
            load = 1'b1; rd_addr = rd_vals[j];
            tick();
            load = 1'b0;
            for (int i = 0; i < 8; i++) begin
                vec_cnt++;
                if (serial_out !== 1'b0 || busy !== 1'b1) begin
                    miss_cnt++;
                    $display("FAIL oor_%h_bit%0d: got so=%b busy=%b want so=0 busy=1",
                             rd_vals[j], i, serial_out, busy);
                end
                tick();
            end
            $display("oor read addr %h: streamed 00", rd_vals[j]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_stream;
        wr_en = 1'b1; wr_addr = 8'd1; wr_data = 8'h81;
        tick();
        wr_addr = 8'd2; wr_data = 8'h7E;
        tick();
        wr_en = 1'b0;
        exp_cfg[7:0]  = 8'h81;
        exp_cfg[15:8] = 8'h7E;
        exp_stream = 16'h817E;
        load = 1'b1; rd_addr = 8'd1;
        tick();
        for (int i = 0; i < 16; i++) begin
            vec_cnt++;
            if (serial_out !== exp_stream[15-i] || busy !== 1'b1) begin
                miss_cnt++;
                $display("FAIL b2b_bit%0d: got so=%b busy=%b want so=%b busy=1",
                         i, serial_out, busy, exp_stream[15-i]);
            end
            load = (i == 7);
            rd_addr = 8'd2;
            tick();
        end
        load = 1'b0;
        vec_cnt++;
        if (busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL b2b_done: got busy=%b want 0", busy);
        end
        $display("back_to_back: streamed 817e");
    endtask

    task automatic test_collision();
        logic [7:0] exp_byte;
        exp_byte = 8'h81;
        wr_en = 1'b1; wr_addr = 8'd1; wr_data = 8'hFF;
        load = 1'b1; rd_addr = 8'd1;
        tick();
        wr_en = 1'b0;
        load  = 1'b0;
        exp_cfg[7:0] = 8'hFF;
        vec_cnt++;
        if (cfg_out !== exp_cfg) begin
            miss_cnt++;
            $display("FAIL collision_cfg: got %h want %h", cfg_out, exp_cfg);
        end
        for (int i = 0; i < 8; i++) begin
            vec_cnt++;
            if (serial_out !== exp_byte[7-i]) begin
                miss_cnt++;
                $display("FAIL collision_bit%0d: got %b want %b", i, serial_out, exp_byte[7-i]);
            end
            tick();
        end
        $display("collision: streamed old 81, cfg1 now %h", cfg_out[7:0]);
    endtask

    task automatic test_abort();
        logic [7:0] exp_byte;
        exp_byte = 8'hA5;
        wr_en = 1'b1; wr_addr = 8'd4; wr_data = exp_byte;
        tick();
        wr_en = 1'b0;
        exp_cfg[31:24] = exp_byte;
        load = 1'b1; rd_addr = 8'd4;
        tick();
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if (serial_out !== exp_byte[7-i]) begin
                miss_cnt++;
                $display("FAIL abort_bit%0d: got %b want %b", i, serial_out, exp_byte[7-i]);
            end
            if (i < 2) tick();
        end
        txn_rstn = 1'b0;
        #1;
        vec_cnt++;
        if (busy !== 1'b0 || serial_out !== 1'b0 || cfg_out !== exp_cfg) begin
            miss_cnt++;
            $display("FAIL abort: got busy=%b so=%b cfg=%h want 0 0 %h",
                     busy, serial_out, cfg_out, exp_cfg);
        end
        txn_rstn = 1'b1;
        tick();
        vec_cnt++;
        if (busy !== 1'b0 || serial_out !== 1'b0) begin
            miss_cnt++;
            $display("FAIL abort_idle: got busy=%b so=%b want 0 0", busy, serial_out);
        end
        $display("abort: busy=%b so=%b cfg=%h", busy, serial_out, cfg_out);
    endtask

    initial begin
        vec_cnt  = 0;
        miss_cnt = 0;
        test_reset();
        test_write_read();
        test_illegal();
        test_status();
        test_oor_read();
        test_back_to_back();
        test_collision();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
